// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit_pkg
//  Purpose  : Shared constants for the multicycle CPU control unit: opcodes,
//             FSM state encoding, ALU operation codes and the datapath mux
//             select codes (PCSrc, ExtSel, RegOut).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package multicycle_control_unit_pkg;

   localparam int OPW = 6;   // opcode width, IR[31:26]
   localparam int STW = 3;   // state register width

   // Instruction opcodes
   localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
   localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
   localparam logic [OPW-1:0] OP_ADDI  = 6'b000010;
   localparam logic [OPW-1:0] OP_OR    = 6'b010000;
   localparam logic [OPW-1:0] OP_AND   = 6'b010001;
   localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
   localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
   localparam logic [OPW-1:0] OP_SLT   = 6'b100110;
   localparam logic [OPW-1:0] OP_SLTIU = 6'b100111;
   localparam logic [OPW-1:0] OP_SW    = 6'b110000;
   localparam logic [OPW-1:0] OP_LW    = 6'b110001;
   localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
   localparam logic [OPW-1:0] OP_J     = 6'b111000;
   localparam logic [OPW-1:0] OP_JR    = 6'b111001;
   localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
   localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

   // FSM states; HALT is not a state of its own but ID plus a sticky flag
   typedef enum logic [STW-1:0] {
      ST_IF     = 3'b000,
      ST_ID     = 3'b001,
      ST_EXE_LS = 3'b010,
      ST_MEM    = 3'b011,
      ST_WB_L   = 3'b100,
      ST_EXE_BR = 3'b101,
      ST_EXE_AL = 3'b110,
      ST_WB_AL  = 3'b111
   } state_e;

   // ALU operations
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_SLL  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_AND  = 3'b100;
   localparam logic [2:0] ALU_SLT  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;

   // Next-PC source
   localparam logic [1:0] PCSRC_SEQ = 2'b00;   // PC+4
   localparam logic [1:0] PCSRC_BR  = 2'b01;   // PC+4+(sext<<2)
   localparam logic [1:0] PCSRC_RS  = 2'b10;   // rs (jr)
   localparam logic [1:0] PCSRC_JMP = 2'b11;   // jump target

   // Immediate extension
   localparam logic [1:0] EXT_ZIMM   = 2'b00;
   localparam logic [1:0] EXT_SIMM   = 2'b01;
   localparam logic [1:0] EXT_ZSHAMT = 2'b10;

   // Destination register select
   localparam logic [1:0] REGOUT_RA = 2'b00;   // $31
   localparam logic [1:0] REGOUT_RT = 2'b01;
   localparam logic [1:0] REGOUT_RD = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit_if
//  Purpose  : Bundle between the control unit and the datapath.
//  Signals  : opcode/zero flow datapath -> control; every control strobe
//             plus the debug state flow control -> datapath.
//  Modports : master - control unit side (drives strobes)
//             slave  - datapath side (drives opcode/zero)
//  Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;
   import multicycle_control_unit_pkg::*;

   logic [OPW-1:0] opcode;
   logic           zero;
   logic           PCWre;
   logic           InsMemRW;
   logic           IRWre;
   logic [1:0]     ExtSel;
   logic [1:0]     RegOut;
   logic           RegWre;
   logic           ALUSrcB;
   logic [2:0]     ALUOp;
   logic           ALUM2Reg;
   logic           WrRegData;
   logic           DataMemRW;
   logic [1:0]     PCSrc;
   logic [STW-1:0] state;

   modport master (
      input  opcode, zero,
      output PCWre, InsMemRW, IRWre, ExtSel, RegOut, RegWre, ALUSrcB,
             ALUOp, ALUM2Reg, WrRegData, DataMemRW, PCSrc, state
   );

   modport slave (
      output opcode, zero,
      input  PCWre, InsMemRW, IRWre, ExtSel, RegOut, RegWre, ALUSrcB,
             ALUOp, ALUM2Reg, WrRegData, DataMemRW, PCSrc, state
   );

endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit_alu_op_decoder
//  Purpose  : Combinational decode of R/I-type ALU opcodes into ALU operation,
//             operand-B source and immediate extension mode.
//  Ports    : opcode_i    - instruction opcode
//             alu_op_o    - ALU operation
//             alu_src_b_o - 1 selects the extended immediate as operand B
//             ext_sel_o   - immediate extension mode
//             is_alu_o    - opcode is an R/I-type ALU instruction
//             is_itype_o  - ALU instruction writes rt (immediate form)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit_alu_op_decoder
   import multicycle_control_unit_pkg::*;
(
   input  logic [OPW-1:0] opcode_i,
   output logic [2:0]     alu_op_o,
   output logic           alu_src_b_o,
   output logic [1:0]     ext_sel_o,
   output logic           is_alu_o,
   output logic           is_itype_o
);

   always_comb begin
      alu_op_o    = ALU_ADD;
      alu_src_b_o = 1'b0;
      ext_sel_o   = EXT_ZIMM;
      is_alu_o    = 1'b1;
      is_itype_o  = 1'b0;
      case (opcode_i)
         OP_ADD:   alu_op_o = ALU_ADD;
         OP_SUB:   alu_op_o = ALU_SUB;
         OP_OR:    alu_op_o = ALU_OR;
         OP_AND:   alu_op_o = ALU_AND;
         OP_SLT:   alu_op_o = ALU_SLT;
         OP_SLL: begin
            alu_op_o  = ALU_SLL;
            ext_sel_o = EXT_ZSHAMT;   // shift amount comes through the extender
         end
         OP_ADDI: begin
            alu_op_o    = ALU_ADD;
            alu_src_b_o = 1'b1;
            ext_sel_o   = EXT_SIMM;
            is_itype_o  = 1'b1;
         end
         OP_ORI: begin
            alu_op_o    = ALU_OR;
            alu_src_b_o = 1'b1;
            is_itype_o  = 1'b1;
         end
         OP_SLTIU: begin
            alu_op_o    = ALU_SLTU;
            alu_src_b_o = 1'b1;
            is_itype_o  = 1'b1;
         end
         default:  is_alu_o = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit
//  Purpose  : Control FSM of the multicycle CPU. Steps each instruction
//             through IF/ID/EXE/MEM/WB and drives all datapath strobes;
//             PCWre pulses exactly once per instruction.
//  Ports    : clk   - clock, rising edge
//             reset - synchronous, active-high; forces all outputs low
//             bus   - master side of multicycle_control_unit_if
//                     (opcode/zero in, control strobes and state out)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   multicycle_control_unit_if.master bus
);

   state_e state_q, state_d;
   logic   halted_q, halted_d;

   logic [2:0] w_dec_alu_op;
   logic       w_dec_src_b;
   logic [1:0] w_dec_ext;
   logic       w_dec_is_alu;
   logic       w_dec_is_itype;

   logic       w_pc_wre, w_ins_mem_rw, w_ir_wre, w_reg_wre, w_alu_src_b;
   logic       w_alu_m2reg, w_wr_reg_data, w_data_mem_rw;
   logic [1:0] w_ext_sel, w_reg_out, w_pc_src;
   logic [2:0] w_alu_op;

   multicycle_control_unit_alu_op_decoder u_alu_op_decoder (
      .opcode_i    (bus.opcode),
      .alu_op_o    (w_dec_alu_op),
      .alu_src_b_o (w_dec_src_b),
      .ext_sel_o   (w_dec_ext),
      .is_alu_o    (w_dec_is_alu),
      .is_itype_o  (w_dec_is_itype)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IF;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   // Operand controls (ALUOp/ALUSrcB/ExtSel) are held from EXE through the
   // closing WB/MEM state so the ALU result stays stable while it is written.
   always_comb begin
      state_d        = state_q;
      halted_d       = halted_q;
      w_pc_wre       = 1'b0;
      w_ins_mem_rw   = 1'b0;
      w_ir_wre       = 1'b0;
      w_ext_sel      = EXT_ZIMM;
      w_reg_out      = REGOUT_RA;
      w_reg_wre      = 1'b0;
      w_alu_src_b    = 1'b0;
      w_alu_op       = ALU_ADD;
      w_alu_m2reg    = 1'b0;
      w_wr_reg_data  = 1'b0;
      w_data_mem_rw  = 1'b0;
      w_pc_src       = PCSRC_SEQ;

      if (reset) begin
         state_d  = ST_IF;
         halted_d = 1'b0;
      end else if (!halted_q) begin
         case (state_q)
            ST_IF: begin
               w_ins_mem_rw = 1'b1;
               w_ir_wre     = 1'b1;
               state_d      = ST_ID;
            end
            ST_ID: begin
               if (bus.opcode == OP_J) begin
                  w_pc_wre = 1'b1;
                  w_pc_src = PCSRC_JMP;
                  state_d  = ST_IF;
               end else if (bus.opcode == OP_JR) begin
                  w_pc_wre = 1'b1;
                  w_pc_src = PCSRC_RS;
                  state_d  = ST_IF;
               end else if (bus.opcode == OP_JAL) begin
                  // link PC+4 into $31 in the same cycle the jump is taken
                  w_pc_wre      = 1'b1;
                  w_pc_src      = PCSRC_JMP;
                  w_reg_wre     = 1'b1;
                  w_reg_out     = REGOUT_RA;
                  w_wr_reg_data = 1'b0;
                  state_d       = ST_IF;
               end else if (bus.opcode == OP_BEQ) begin
                  state_d = ST_EXE_BR;
               end else if (bus.opcode == OP_SW || bus.opcode == OP_LW) begin
                  state_d = ST_EXE_LS;
               end else if (bus.opcode == OP_HALT) begin
                  halted_d = 1'b1;
                  state_d  = ST_ID;
               end else if (w_dec_is_alu) begin
                  state_d = ST_EXE_AL;
               end else begin
                  // undefined opcode retires as a nop
                  w_pc_wre = 1'b1;
                  w_pc_src = PCSRC_SEQ;
                  state_d  = ST_IF;
               end
            end
            ST_EXE_AL: begin
               w_alu_op    = w_dec_alu_op;
               w_alu_src_b = w_dec_src_b;
               w_ext_sel   = w_dec_ext;
               state_d     = ST_WB_AL;
            end
            ST_WB_AL: begin
               w_alu_op      = w_dec_alu_op;
               w_alu_src_b   = w_dec_src_b;
               w_ext_sel     = w_dec_ext;
               w_reg_wre     = 1'b1;
               w_reg_out     = w_dec_is_itype ? REGOUT_RT : REGOUT_RD;
               w_wr_reg_data = 1'b1;
               w_alu_m2reg   = 1'b0;
               w_pc_wre      = 1'b1;
               w_pc_src      = PCSRC_SEQ;
               state_d       = ST_IF;
            end
            ST_EXE_BR: begin
               w_alu_op    = ALU_SUB;
               w_alu_src_b = 1'b0;
               w_ext_sel   = EXT_SIMM;
               w_pc_wre    = 1'b1;
               w_pc_src    = bus.zero ? PCSRC_BR : PCSRC_SEQ;
               state_d     = ST_IF;
            end
            ST_EXE_LS: begin
               w_alu_op    = ALU_ADD;
               w_alu_src_b = 1'b1;
               w_ext_sel   = EXT_SIMM;
               state_d     = ST_MEM;
            end
            ST_MEM: begin
               w_alu_op    = ALU_ADD;
               w_alu_src_b = 1'b1;
               w_ext_sel   = EXT_SIMM;
               if (bus.opcode == OP_SW) begin
                  w_data_mem_rw = 1'b1;
                  w_pc_wre      = 1'b1;
                  state_d       = ST_IF;
               end else begin
                  state_d = ST_WB_L;
               end
            end
            ST_WB_L: begin
               w_alu_op      = ALU_ADD;
               w_alu_src_b   = 1'b1;
               w_ext_sel     = EXT_SIMM;
               w_reg_wre     = 1'b1;
               w_reg_out     = REGOUT_RT;
               w_alu_m2reg   = 1'b1;
               w_wr_reg_data = 1'b1;
               w_pc_wre      = 1'b1;
               state_d       = ST_IF;
            end
            default: state_d = ST_IF;
         endcase
      end
   end

   assign bus.PCWre     = w_pc_wre;
   assign bus.InsMemRW  = w_ins_mem_rw;
   assign bus.IRWre     = w_ir_wre;
   assign bus.ExtSel    = w_ext_sel;
   assign bus.RegOut    = w_reg_out;
   assign bus.RegWre    = w_reg_wre;
   assign bus.ALUSrcB   = w_alu_src_b;
   assign bus.ALUOp     = w_alu_op;
   assign bus.ALUM2Reg  = w_alu_m2reg;
   assign bus.WrRegData = w_wr_reg_data;
   assign bus.DataMemRW = w_data_mem_rw;
   assign bus.PCSrc     = w_pc_src;
   // Debug state reads IF (all zeros) while reset is held.
   assign bus.state     = reset ? ST_IF : state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control_unit
//  Purpose  : Self-checking bench for multicycle_control_unit: latency/strobe
//             vector table, random instruction stream against a per-cycle
//             reference model, and hand sequences for halt and mid-instruction
//             reset.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
   localparam logic [5:0] OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
   localparam logic [5:0] SLL = 6'b011000, SLT = 6'b100110, SLTIU = 6'b100111;
   localparam logic [5:0] SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100;
   localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010;
   localparam logic [5:0] HALT = 6'b111111, UNDEF = 6'b101010;

   typedef struct packed {
      logic [2:0] state;
      logic       pcwre;
      logic       insmem;
      logic       irwre;
      logic [1:0] ext;
      logic [1:0] regout;
      logic       regwre;
      logic       srcb;
      logic [2:0] aluop;
      logic       m2reg;
      logic       wrdata;
      logic       memrw;
      logic [1:0] pcsrc;
   } ctl_t;

   typedef struct {
      logic [5:0] op;
      logic       z;
      int         lat;
      logic [1:0] pcsrc;
      logic       regwre;
      logic [1:0] regout;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   ctl_t exp_q[$];
   ctl_t act;
   vec_t vt[10];

   multicycle_control_unit_if bus();

   multicycle_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   assign act = {bus.state, bus.PCWre, bus.InsMemRW, bus.IRWre, bus.ExtSel,
                 bus.RegOut, bus.RegWre, bus.ALUSrcB, bus.ALUOp, bus.ALUM2Reg,
                 bus.WrRegData, bus.DataMemRW, bus.PCSrc};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic bit is_defined(input logic [5:0] op);
      return op inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTIU,
                        SW, LW, BEQ, J, JR, JAL, HALT};
   endfunction

   // ALU-class instruction properties straight from the instruction list
   function automatic bit alu_info(input logic [5:0] op, output logic [2:0] aop,
                                   output logic sb, output logic [1:0] ex,
                                   output logic it);
      aop = 3'd0; sb = 1'b0; ex = 2'd0; it = 1'b0;
      case (op)
         ADD:   begin aop = 3'd0; return 1'b1; end
         SUB:   begin aop = 3'd1; return 1'b1; end
         SLL:   begin aop = 3'd2; ex = 2'd2; return 1'b1; end
         OR_:   begin aop = 3'd3; return 1'b1; end
         AND_:  begin aop = 3'd4; return 1'b1; end
         SLT:   begin aop = 3'd5; return 1'b1; end
         ADDI:  begin aop = 3'd0; sb = 1'b1; ex = 2'd1; it = 1'b1; return 1'b1; end
         ORI:   begin aop = 3'd3; sb = 1'b1; it = 1'b1; return 1'b1; end
         SLTIU: begin aop = 3'd6; sb = 1'b1; it = 1'b1; return 1'b1; end
         default: return 1'b0;
      endcase
   endfunction

   // Reference model: queue up the expected control word of every cycle of one instruction
   task automatic push_expect(input logic [5:0] op, input logic z);
      ctl_t r, id;
      logic [2:0] aop; logic sb, it; logic [1:0] ex; bit alu;
      alu = alu_info(op, aop, sb, ex, it);
      r = '0; r.state = 3'd0; r.insmem = 1'b1; r.irwre = 1'b1;
      exp_q.push_back(r);
      id = '0; id.state = 3'd1;
      if (op == J || op == JR || op == JAL) begin
         r = id; r.pcwre = 1'b1; r.pcsrc = (op == JR) ? 2'd2 : 2'd3;
         if (op == JAL) begin r.regwre = 1'b1; r.regout = 2'd0; r.wrdata = 1'b0; end
         exp_q.push_back(r);
      end else if (op == BEQ) begin
         exp_q.push_back(id);
         r = '0; r.state = 3'd5; r.aluop = 3'd1; r.ext = 2'd1; r.pcwre = 1'b1;
         r.pcsrc = z ? 2'd1 : 2'd0;
         exp_q.push_back(r);
      end else if (op == SW || op == LW) begin
         exp_q.push_back(id);
         r = '0; r.aluop = 3'd0; r.srcb = 1'b1; r.ext = 2'd1;
         r.state = 3'd2; exp_q.push_back(r);
         r.state = 3'd3;
         if (op == SW) begin r.memrw = 1'b1; r.pcwre = 1'b1; end
         exp_q.push_back(r);
         if (op == LW) begin
            r.state = 3'd4; r.regwre = 1'b1; r.regout = 2'd1; r.m2reg = 1'b1;
            r.wrdata = 1'b1; r.pcwre = 1'b1;
            exp_q.push_back(r);
         end
      end else if (alu) begin
         exp_q.push_back(id);
         r = '0; r.aluop = aop; r.srcb = sb; r.ext = ex;
         r.state = 3'd6; exp_q.push_back(r);
         r.state = 3'd7; r.regwre = 1'b1; r.regout = it ? 2'd1 : 2'd2;
         r.wrdata = 1'b1; r.pcwre = 1'b1;
         exp_q.push_back(r);
      end else begin
         r = id; r.pcwre = 1'b1; r.pcsrc = 2'd0;
         exp_q.push_back(r);
      end
   endtask

   // Entered just after a rising edge with the DUT in IF.
   task automatic run_instr(input logic [5:0] op, input logic z, input string name);
      ctl_t e;
      int   pc_cnt;
      pc_cnt = 0;
      push_expect(op, z);
      bus.opcode = op;
      bus.zero   = z;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         chk(name, 32'(act), 32'(e));
         if (act.pcwre) pc_cnt++;
         @(posedge clk); #1;
      end
      chk({name, "_pcwre_once"}, 32'(pc_cnt), 32'd1);
   endtask

   initial begin
      ctl_t e, hz;
      logic [5:0] rop;
      logic [5:0] pool[15];
      bit found;
      int k;

      vt[0] = '{LW,    1'b1, 5, 2'd0, 1'b1, 2'd1};
      vt[1] = '{SW,    1'b0, 4, 2'd0, 1'b0, 2'd0};
      vt[2] = '{BEQ,   1'b1, 3, 2'd1, 1'b0, 2'd0};
      vt[3] = '{BEQ,   1'b0, 3, 2'd0, 1'b0, 2'd0};
      vt[4] = '{ADD,   1'b0, 4, 2'd0, 1'b1, 2'd2};
      vt[5] = '{ADDI,  1'b0, 4, 2'd0, 1'b1, 2'd1};
      vt[6] = '{J,     1'b0, 2, 2'd3, 1'b0, 2'd0};
      vt[7] = '{JR,    1'b0, 2, 2'd2, 1'b0, 2'd0};
      vt[8] = '{JAL,   1'b0, 2, 2'd3, 1'b1, 2'd0};
      vt[9] = '{UNDEF, 1'b0, 2, 2'd0, 1'b0, 2'd0};

      pool = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTIU, SW, LW, BEQ, J, JR, JAL};

      // Reset state: everything low while reset is held
      bus.opcode = SW;
      bus.zero   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 32'(act), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // lw from reset, then beq taken/not taken, jal, add, addi
      run_instr(LW,   1'b0, "lw_seq");
      run_instr(BEQ,  1'b1, "beq_taken");
      run_instr(BEQ,  1'b0, "beq_not_taken");
      run_instr(JAL,  1'b0, "jal");
      run_instr(ADD,  1'b0, "add");
      run_instr(ADDI, 1'b0, "addi");

      // Latency / retiring-cycle vector table
      for (int i = 0; i < 10; i++) begin
         bus.opcode = vt[i].op;
         bus.zero   = vt[i].z;
         found = 1'b0;
         k = 0;
         for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.PCWre) begin
               found = 1'b1;
               k = c;
               chk($sformatf("vec%0d_pcsrc", i), 32'(bus.PCSrc), 32'(vt[i].pcsrc));
               chk($sformatf("vec%0d_regwre", i), 32'(bus.RegWre), 32'(vt[i].regwre));
               if (vt[i].regwre)
                  chk($sformatf("vec%0d_regout", i), 32'(bus.RegOut), 32'(vt[i].regout));
            end
            @(posedge clk); #1;
            if (found) break;
         end
         chk($sformatf("vec%0d_latency", i), 32'(k), 32'(vt[i].lat));
      end

      // Random instruction stream against the reference model
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            rop = 6'($urandom);
            for (int t = 0; t < 10 && is_defined(rop); t++) rop = 6'($urandom);
            if (is_defined(rop)) rop = UNDEF;
         end else begin
            rop = pool[$urandom_range(0, 14)];
         end
         run_instr(rop, 1'($urandom), $sformatf("rand%0d_op%b", n, rop));
      end

      // Halt: sticks in ID with every strobe low until reset
      bus.opcode = HALT;
      bus.zero   = 1'b0;
      push_expect(HALT, 1'b0);
      e = exp_q.pop_front();
      @(negedge clk);
      chk("halt_if", 32'(act), 32'(e));
      exp_q.delete();
      hz = '0; hz.state = 3'd1;
      for (int c = 0; c < 21; c++) begin
         @(posedge clk); #1;
         bus.zero = 1'($urandom);
         @(negedge clk);
         chk($sformatf("halt_hold%0d", c), 32'(act), 32'(hz));
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("halt_reset_outputs", 32'(act), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      run_instr(ADD, 1'b0, "after_halt_add");

      // Reset during MEM of sw: no write that cycle, restart at IF
      bus.opcode = SW;
      bus.zero   = 1'b0;
      push_expect(SW, 1'b0);
      for (int c = 0; c < 3; c++) begin
         e = exp_q.pop_front();
         @(negedge clk);
         chk($sformatf("sw_abort_c%0d", c), 32'(act), 32'(e));
         @(posedge clk); #1;
      end
      exp_q.delete();
      reset = 1'b1;
      @(negedge clk);
      chk("sw_abort_memrw", 32'(bus.DataMemRW), 32'd0);
      chk("sw_abort_outputs", 32'(act), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      run_instr(UNDEF, 1'b0, "nop_after_abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute guard so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
